mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have port CLK  input  1  rising-edge clock for all state.
REQ-002 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port REQ  input  3  per-requester request; bit0 system processor, bit1 game processor, bit2 GPU fetch.
REQ-004 SHALL have port WE  input  3  per-requester write select (1 write, 0 read).
REQ-005 SHALL have ports ADDR0/ADDR1/ADDR2  input  16 each  per-requester address.
REQ-006 SHALL have ports WDATA0/WDATA1/WDATA2  input  16 each  per-requester write data.
REQ-007 SHALL have port GNT  output  3  one-hot grant, held for the whole transaction.
REQ-008 SHALL have port DONE  output  3  one-hot, one-cycle completion pulse.
REQ-009 SHALL have port RDATA  output  16  read data, valid while any DONE bit is high.
REQ-010 SHALL have ports MEM_ENABLE out 1, MEM_WRITE out 1, MEM_ADDR out 16, MEM_DATA_W out 16, MEM_DATA_R in 16, MEM_READY in 1, all on the memory-controller side.
REQ-011 SHALL have port TIMEOUT_ERR  output  1  sticky memory-timeout flag.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE: SHALL arbitrate when REQ!=0 and register winner, WE, address and write data; next state BUSY; REQ==0 stays IDLE.
REQ-014 Arbitration SHALL be round-robin: search starts at (last granted index + 1) mod 3, ascending with wrap; pointer updates only on grant.
REQ-015 BUSY: MEM_ENABLE=1; MEM_WRITE/MEM_ADDR/MEM_DATA_W driven from registered values, stable; GNT bit high.
REQ-016 BUSY exits to DONE on the first cycle MEM_READY=1; MEM_DATA_R SHALL be captured into RDATA on that edge.
REQ-017 DONE: exactly one DONE bit (matching grant) high for one cycle; GNT still high; MEM_ENABLE=0; next state IDLE unconditionally.
REQ-018 Minimum latency: REQ sampled at edge N, MEM_ENABLE high cycle N+1, DONE high cycle N+2 if MEM_READY=1 in N+1.
REQ-019 Requester SHALL hold REQ/WE/ADDR/WDATA until DONE; REQ deassertion during BUSY SHALL NOT abort the transaction.
REQ-020 REQ still high in the cycle after DONE SHALL be treated as a new request subject to round-robin.
REQ-021 RDATA SHALL hold last captured value until next capture; for writes RDATA is unchanged.
REQ-022 MEM_READY in IDLE or DONE SHALL be ignored.
REQ-023 GNT and DONE SHALL always be zero or one-hot.

Reset
REQ-024 RESET SHALL force state IDLE, GNT=0, DONE=0, MEM_ENABLE=0, MEM_WRITE=0, MEM_ADDR=0, MEM_DATA_W=0, RDATA=0, TIMEOUT_ERR=0, round-robin pointer=2 (requester 0 first).
REQ-025 RESET during BUSY SHALL abandon the transaction with no DONE pulse; RESET overrides all other inputs.

Configuration
REQ-026 With macro MEM_BUS_ARBITER_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle; at 255 with MEM_READY=0 the FSM SHALL go to DONE with RDATA=16'hFFFF and set TIMEOUT_ERR until RESET.
REQ-027 Without MEM_BUS_ARBITER_TIMEOUT_EN: no counter; BUSY waits indefinitely; TIMEOUT_ERR tied 0.

Verification
REQ-028 After reset, REQ=3'b111, MEM_READY=1 always -> grants in order 001,010,100,001, each DONE 2 cycles after grant decision.
REQ-029 REQ=3'b010, WE=0, ADDR1=16'h1234, MEM_DATA_R=16'hBEEF, MEM_READY after 3 BUSY cycles -> MEM_ADDR=16'h1234 throughout BUSY, DONE=3'b010 with RDATA=16'hBEEF.
REQ-030 REQ=3'b001, WE=1, WDATA0=16'hA5A5 -> MEM_WRITE=1, MEM_DATA_W=16'hA5A5 in BUSY, RDATA unchanged at DONE.
REQ-031 RESET asserted in 2nd BUSY cycle -> next cycle GNT=0, MEM_ENABLE=0, no DONE; next REQ=3'b111 granted to 001.
REQ-032 REQ bit dropped mid-BUSY -> transaction still completes with DONE pulse.
REQ-033 TIMEOUT_EN build, MEM_READY held 0 -> DONE after 256 BUSY cycles, RDATA=16'hFFFF, TIMEOUT_ERR=1 until RESET.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Three-requester round-robin arbiter in front of a single memory controller.
// Define MEM_BUS_ARBITER_TIMEOUT_EN to add an 8-bit memory-ready timeout with a sticky TIMEOUT_ERR.
module mem_bus_arbiter (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [2:0]  REQ,
   input  logic [2:0]  WE,
   input  logic [15:0] ADDR0,
   input  logic [15:0] ADDR1,
   input  logic [15:0] ADDR2,
   input  logic [15:0] WDATA0,
   input  logic [15:0] WDATA1,
   input  logic [15:0] WDATA2,
   output logic [2:0]  GNT,
   output logic [2:0]  DONE,
   output logic [15:0] RDATA,
   output logic        MEM_ENABLE,
   output logic        MEM_WRITE,
   output logic [15:0] MEM_ADDR,
   output logic [15:0] MEM_DATA_W,
   input  logic [15:0] MEM_DATA_R,
   input  logic        MEM_READY,
   output logic        TIMEOUT_ERR
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [2:0]  gnt_q, gnt_d;
   logic [1:0]  last_q, last_d;
   logic        we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;

   logic [1:0]  cand0, cand1, cand2, win_idx;
   logic [15:0] win_addr, win_wdata;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
   logic [7:0]  cnt_q, cnt_d;
   logic        terr_q, terr_d;
`endif

   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   // Search order starts one past the last winner and wraps through all three.
   always_comb begin
      cand0 = rr_next(last_q);
      cand1 = rr_next(cand0);
      cand2 = rr_next(cand1);
      if (REQ[cand0])      win_idx = cand0;
      else if (REQ[cand1]) win_idx = cand1;
      else                 win_idx = cand2;
   end

   always_comb begin
      case (win_idx)
         2'd0:    begin win_addr = ADDR0; win_wdata = WDATA0; end
         2'd1:    begin win_addr = ADDR1; win_wdata = WDATA1; end
         default: begin win_addr = ADDR2; win_wdata = WDATA2; end
      endcase
   end

   // NOTE: every next-state signal takes its current value first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
      cnt_d   = cnt_q;
      terr_d  = terr_q;
`endif
      case (state_q)
         S_IDLE: begin
            gnt_d = 3'b000;
            if (|REQ) begin
               state_d = S_BUSY;
               gnt_d   = 3'b001 << win_idx;
               last_d  = win_idx;
               we_d    = WE[win_idx];
               addr_d  = win_addr;
               wdata_d = win_wdata;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
               cnt_d   = 8'd0;
`endif
            end
         end
         S_BUSY: begin
            if (MEM_READY) begin
               state_d = S_DONE;
               if (!we_q) rdata_d = MEM_DATA_R;
            end
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
            else if (cnt_q == 8'hFF) begin
               state_d = S_DONE;
               rdata_d = 16'hFFFF;
               terr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
            gnt_d   = 3'b000;
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = 3'b000;
         end
      endcase
   end

   // NOTE: reset is synchronous and also clears the datapath registers, since they drive the bus directly.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         gnt_q   <= 3'b000;
         last_q  <= 2'd2;
         we_q    <= 1'b0;
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
         rdata_q <= 16'h0000;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
         cnt_q   <= 8'd0;
         terr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
`endif
      end
   end

   assign GNT        = gnt_q;
   assign DONE       = (state_q == S_DONE) ? gnt_q : 3'b000;
   assign MEM_ENABLE = (state_q == S_BUSY);
   assign MEM_WRITE  = we_q;
   assign MEM_ADDR   = addr_q;
   assign MEM_DATA_W = wdata_q;
   assign RDATA      = rdata_q;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
   assign TIMEOUT_ERR = terr_q;
`else
   assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a transaction-level reference model fills queues,
// a negedge monitor compares every DUT cycle against them.
module tb_mem_bus_arbiter;

   logic        CLK;
   logic        RESET;
   logic [2:0]  REQ, WE;
   logic [15:0] addr_a [3];
   logic [15:0] wdata_a [3];
   logic [2:0]  GNT, DONE;
   logic [15:0] RDATA;
   logic        MEM_ENABLE, MEM_WRITE;
   logic [15:0] MEM_ADDR, MEM_DATA_W, MEM_DATA_R;
   logic        MEM_READY, TIMEOUT_ERR;

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 0;

   mem_bus_arbiter dut (
      .CLK(CLK), .RESET(RESET), .REQ(REQ), .WE(WE),
      .ADDR0(addr_a[0]), .ADDR1(addr_a[1]), .ADDR2(addr_a[2]),
      .WDATA0(wdata_a[0]), .WDATA1(wdata_a[1]), .WDATA2(wdata_a[2]),
      .GNT(GNT), .DONE(DONE), .RDATA(RDATA),
      .MEM_ENABLE(MEM_ENABLE), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
      .MEM_DATA_W(MEM_DATA_W), .MEM_DATA_R(MEM_DATA_R), .MEM_READY(MEM_READY),
      .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          idx;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
   } txn_t;

   typedef enum {T_NONE, T_MEM, T_ACK} tphase_e;

   txn_t        gq[$];     // granted, waiting for completion
   txn_t        dq[$];     // completed, DONE expected this cycle
   txn_t        m_cur;
   tphase_e     m_phase;
   int          m_ptr, m_w, m_wait;
   logic [15:0] m_rdata;
   logic        m_terr;

   function automatic int rr_pick(input int last, input logic [2:0] req);
      for (int k = 1; k <= 3; k++)
         if (req[(last + k) % 3]) return (last + k) % 3;
      return -1;
   endfunction

   initial begin
      m_phase = T_NONE; m_ptr = 2; m_rdata = '0; m_terr = 1'b0; m_wait = 0; m_w = 0;
      forever begin
         @(posedge CLK);
         if (RESET === 1'b1) begin
            m_phase = T_NONE; m_ptr = 2; m_rdata = '0; m_terr = 1'b0;
            gq.delete(); dq.delete();
         end else begin
            case (m_phase)
               T_NONE: if (REQ != 3'b000) begin
                  m_w         = rr_pick(m_ptr, REQ);
                  m_ptr       = m_w;
                  m_cur.idx   = m_w;
                  m_cur.we    = WE[m_w];
                  m_cur.addr  = addr_a[m_w];
                  m_cur.wdata = wdata_a[m_w];
                  m_cur.rdata = '0;
                  gq.push_back(m_cur);
                  m_wait  = 0;
                  m_phase = T_MEM;
               end
               T_MEM: begin
                  if (MEM_READY) begin
                     if (!m_cur.we) m_rdata = MEM_DATA_R;
                     m_cur.rdata = m_rdata;
                     dq.push_back(m_cur);
                     m_phase = T_ACK;
                  end
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
                  else if (m_wait == 255) begin
                     m_rdata = 16'hFFFF;
                     m_terr  = 1'b1;
                     m_cur.rdata = m_rdata;
                     dq.push_back(m_cur);
                     m_phase = T_ACK;
                  end else begin
                     m_wait++;
                  end
`endif
               end
               default: m_phase = T_NONE;
            endcase
         end
      end
   end

   // ---------------- monitor ----------------
   logic [2:0] e_gnt, e_done;
   logic       e_en;

   initial begin
      forever begin
         @(negedge CLK);
         if (mon_en) begin
            e_gnt  = (gq.size() != 0) ? (3'b001 << gq[0].idx) : 3'b000;
            e_done = (dq.size() != 0) ? (3'b001 << dq[0].idx) : 3'b000;
            e_en   = (gq.size() != 0) && (dq.size() == 0);
            check("gnt", {29'd0, GNT}, {29'd0, e_gnt});
            check("done", {29'd0, DONE}, {29'd0, e_done});
            check("mem_enable", {31'd0, MEM_ENABLE}, {31'd0, e_en});
            check("timeout_err", {31'd0, TIMEOUT_ERR}, {31'd0, m_terr});
            check("gnt_onehot0", {31'd0, $onehot0(GNT)}, 32'd1);
            if (dq.size() != 0) check("rdata_at_done", {16'd0, RDATA}, {16'd0, dq[0].rdata});
            else                check("rdata_hold", {16'd0, RDATA}, {16'd0, m_rdata});
            if (e_en) begin
               check("mem_addr", {16'd0, MEM_ADDR}, {16'd0, gq[0].addr});
               check("mem_write", {31'd0, MEM_WRITE}, {31'd0, gq[0].we});
               check("mem_data_w", {16'd0, MEM_DATA_W}, {16'd0, gq[0].wdata});
            end
            if (dq.size() != 0) begin
               dq.delete(0);
               if (gq.size() != 0) gq.delete(0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1; REQ = 3'b000; WE = 3'b000;
      for (int i = 0; i < 3; i++) begin addr_a[i] = '0; wdata_a[i] = '0; end
      MEM_READY = 1'b0; MEM_DATA_R = '0;
      step(); step();
      RESET = 1'b0;
      check("rst_gnt", {29'd0, GNT}, 32'd0);
      check("rst_done", {29'd0, DONE}, 32'd0);
      check("rst_en", {31'd0, MEM_ENABLE}, 32'd0);
      check("rst_write", {31'd0, MEM_WRITE}, 32'd0);
      check("rst_addr", {16'd0, MEM_ADDR}, 32'd0);
      check("rst_wdata", {16'd0, MEM_DATA_W}, 32'd0);
      check("rst_rdata", {16'd0, RDATA}, 32'd0);
      check("rst_terr", {31'd0, TIMEOUT_ERR}, 32'd0);
   endtask

   logic [2:0] order [4];
   logic [2:0] eg, ed;
   logic [2:0] active;
   int         n;

   initial begin
      do_reset();
      mon_en = 1;

      // all three requesting, memory always ready: strict rotation
      order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
      REQ = 3'b111; MEM_READY = 1'b1; MEM_DATA_R = 16'h5555;
      addr_a[0] = 16'h1000; addr_a[1] = 16'h2000; addr_a[2] = 16'h3000;
      for (int t = 0; t < 12; t++) begin
         step();
         eg = (t % 3 == 2) ? 3'b000 : order[t / 3];
         ed = (t % 3 == 1) ? order[t / 3] : 3'b000;
         check("rr_gnt", {29'd0, GNT}, {29'd0, eg});
         check("rr_done", {29'd0, DONE}, {29'd0, ed});
      end
      REQ = 3'b000; MEM_READY = 1'b0;
      step();

      // read from requester 1 with three wait cycles
      REQ = 3'b010; WE = 3'b000; addr_a[1] = 16'h1234; MEM_DATA_R = 16'hBEEF;
      for (int b = 0; b < 4; b++) begin
         step();
         check("rd_busy_addr", {16'd0, MEM_ADDR}, 32'h1234);
         check("rd_busy_en", {31'd0, MEM_ENABLE}, 32'd1);
      end
      MEM_READY = 1'b1;
      step();
      check("rd_done", {29'd0, DONE}, 32'b010);
      check("rd_rdata", {16'd0, RDATA}, 32'hBEEF);
      REQ = 3'b000; MEM_READY = 1'b0;
      step();

      // write from requester 0 leaves RDATA alone
      REQ = 3'b001; WE = 3'b001; addr_a[0] = 16'h00C0; wdata_a[0] = 16'hA5A5;
      MEM_DATA_R = 16'h1111; MEM_READY = 1'b1;
      step();
      check("wr_write", {31'd0, MEM_WRITE}, 32'd1);
      check("wr_data", {16'd0, MEM_DATA_W}, 32'hA5A5);
      step();
      check("wr_done", {29'd0, DONE}, 32'b001);
      check("wr_rdata_kept", {16'd0, RDATA}, 32'hBEEF);
      REQ = 3'b000; WE = 3'b000; MEM_READY = 1'b0;
      step();

      // request withdrawn mid-transaction still completes
      REQ = 3'b100; addr_a[2] = 16'h0777; MEM_DATA_R = 16'h2222;
      step();
      REQ = 3'b000;
      step(); step();
      MEM_READY = 1'b1;
      step();
      check("drop_done", {29'd0, DONE}, 32'b100);
      check("drop_rdata", {16'd0, RDATA}, 32'h2222);
      MEM_READY = 1'b0;
      step();

      // reset in the second busy cycle abandons the transfer and restores the pointer
      REQ = 3'b111;
      step(); step();
      RESET = 1'b1;
      step();
      check("rstbusy_gnt", {29'd0, GNT}, 32'd0);
      check("rstbusy_en", {31'd0, MEM_ENABLE}, 32'd0);
      check("rstbusy_done", {29'd0, DONE}, 32'd0);
      RESET = 1'b0;
      step();
      check("rstbusy_regrant", {29'd0, GNT}, 32'b001);
      MEM_READY = 1'b1;
      step();
      check("rstbusy_complete", {29'd0, DONE}, 32'b001);
      REQ = 3'b000; MEM_READY = 1'b0;
      step();

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
      REQ = 3'b010; WE = 3'b000; MEM_READY = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (DONE == 3'b000 && n < 400);
      check("to_latency", n, 257);
      check("to_rdata", {16'd0, RDATA}, 32'hFFFF);
      check("to_err", {31'd0, TIMEOUT_ERR}, 32'd1);
      REQ = 3'b000;
      step(); step();
      check("to_err_sticky", {31'd0, TIMEOUT_ERR}, 32'd1);
      do_reset();
`endif

      // randomized traffic
      active = 3'b000;
      for (int c = 0; c < 3000; c++) begin
         step();
         RESET = ($urandom_range(0, 599) == 0);
         if (RESET) begin
            active = 3'b000; REQ = 3'b000;
         end else begin
            for (int i = 0; i < 3; i++) begin
               if (active[i] && DONE[i]) active[i] = 1'b0;
               if (!active[i]) begin
                  if ($urandom_range(0, 2) == 0) begin
                     active[i]  = 1'b1;
                     REQ[i]     = 1'b1;
                     WE[i]      = 1'($urandom);
                     addr_a[i]  = 16'($urandom);
                     wdata_a[i] = 16'($urandom);
                  end else begin
                     REQ[i] = 1'b0;
                  end
               end else if (GNT[i] && !DONE[i] && $urandom_range(0, 7) == 0) begin
                  REQ[i] = 1'b0;
               end
            end
         end
         MEM_READY  = ($urandom_range(0, 2) == 0);
         MEM_DATA_R = 16'($urandom);
      end

      RESET = 1'b0; REQ = 3'b000; MEM_READY = 1'b1;
      for (int d = 0; d < 8; d++) step();
      check("sb_drained", gq.size() + dq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
